onewire_ctrl: RTL and testbench
===============================

// Module: onewire_ctrl
// PURPOSE
//  Synthesizable 1-wire bus master sequencer: accepts reset/byte/bit commands over a valid/ready
//  port and generates standard-speed 1-wire slot timing on an open-drain line.
//  Sits between a host/CPU command source and the pulled-up owr wire. Replaces the behavioural
//  master model in system-level benches.
// PARAMETERS
//  CLK_PER_US  50  clock cycles per microsecond; all slot timing derives from it (>=2)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  controller idle, command accepted when valid&&ready
//  cmd_op       in   2  00=RESET, 01=BYTE (8-bit exchange, LSB first), 10=BIT (data[0]), 11=reserved
//  cmd_data     in   8  write data (all 1s = pure read)
//  rsp_valid    out  1  one-cycle completion pulse, no backpressure
//  rsp_data     out  8  read data (BIT: {7'b0,bit})
//  rsp_presence out  1  presence detected (RESET only, else 0)
//  owr_oe       out  1  1 = drive line low; 0 = release (external pullup)
//  owr_i        in   1  line level, asynchronous to clk
// BEHAVIOUR
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_presence=0, owr_oe=0; state IDLE.
//  owr_i passes a 2-FF synchronizer; every "sample" uses the synchronized value.
//  Timebase: prescaler counts 0..CLK_PER_US-1 producing a us tick; us counter counts phase time.
//   Both clear on command accept, so a phase of N us lasts exactly N*CLK_PER_US clocks.
//  States/transitions (times in us from phase start):
//   IDLE    : cmd_ready=1; on accept latch op/data, bit_cnt=0, go RST_LO (RESET) or SLOT_LO (BYTE/BIT)
//   RST_LO  : owr_oe=1 for 480 -> RST_WT
//   RST_WT  : released; at 70 sample, presence=~owr_s -> RST_REC
//   RST_REC : released for 410 (reset total 960) -> DONE
//   SLOT_LO : owr_oe=1 for 6 if data[bit_cnt]=1, else 60 -> SLOT_HI
//   SLOT_HI : released; sample at slot time 15 (write-1 only; write-0 records 0);
//             release held until slot time 70 (write-0: 10 us recovery) -> next
//             next: BIT or bit_cnt==7 -> DONE, else bit_cnt++ -> SLOT_LO
//   DONE    : one cycle; rsp_valid=1 with rsp_data/rsp_presence -> IDLE
//  Reserved op 11: accepted, no bus activity, DONE next cycle with rsp_data=8'hFF, presence=0.
//  Read bits shift into rsp_data LSB first; rsp_data/rsp_presence hold until next rsp_valid.
//  owr_oe registered: asserts the cycle after accept; first response possible 1 cycle after DONE entry.
//  cmd_valid while busy ignored (cmd_ready=0); next command acceptable the cycle after rsp_valid.
//  Line stuck low during release phases not flagged; sampled value used as-is.
//  Async reset mid-operation: owr_oe drops immediately, no rsp_valid issued, state IDLE.
//  Counter widths sized for 480*CLK_PER_US; no wrap within any phase.
// TESTING (CLK_PER_US=4)
//  RESET, slave pulls low 15..120us after release -> owr_oe high exactly 1920 clks, rsp_valid
//   3840+1 clks after accept, rsp_presence=1.
//  RESET, no slave (line idle high) -> rsp_presence=0, identical timing.
//  BYTE 0x55, passive bus -> low pulses 24,240,24,240... clks, slots 280 clks, rsp_data=0x55.
//  BYTE 0xFF, slave holds line low through sample for bits of 0xA3's zeros -> rsp_data=0xA3.
//  BIT data=0 then BIT data=1 back-to-back (cmd_valid held) -> second accept the cycle after first
//   rsp_valid; cmd_ready low and extra commands ignored while busy.
//  rst_n low at bit 3 of BYTE -> owr_oe=0 same cycle, no rsp_valid; RESET after release works.

Source files
------------

// File: rtl/onewire_ctrl.sv
// onewire_ctrl: 1-wire bus master sequencer. Turns RESET/BYTE/BIT commands into
// standard-speed slot timing on an open-drain line (owr_oe=1 pulls the wire low).
module onewire_ctrl #(
  parameter int CLK_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       owr_oe,
  input  logic       owr_i
);

  localparam int               PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_US - 1);
  localparam logic [1:0]       OP_RESET = 2'b00;
  localparam logic [1:0]       OP_BYTE  = 2'b01;
  localparam logic [1:0]       OP_BIT   = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RST_LO, RST_WT, RST_REC, SLOT_LO, SLOT_HI, DONE
  } state_t;

  state_t           state, next_state;
  logic [PRE_W-1:0] pre_cnt;
  logic [8:0]       us_cnt;
  logic [1:0]       op_q;
  logic [7:0]       data_q;
  logic [2:0]       bit_cnt;
  logic [7:0]       rd_shift;
  logic             rd_bit;
  logic             pres_q;
  logic             owr_meta, owr_s;
  logic             accept, tick, oe_next, cnt_clear, cur_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // tick marks the last clock of each microsecond, so "tick && us_cnt==N-1" ends an N us phase
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RESET:       next_state = RST_LO;
            OP_BYTE,OP_BIT: next_state = SLOT_LO;
            default:        next_state = DONE;
          endcase
        end
      end
      RST_LO:  if (tick && us_cnt == 9'd479) next_state = RST_WT;
      RST_WT:  if (tick && us_cnt == 9'd69)  next_state = RST_REC;
      RST_REC: if (tick && us_cnt == 9'd409) next_state = DONE;
      SLOT_LO: if (tick && us_cnt == (cur_bit ? 9'd5 : 9'd59)) next_state = SLOT_HI;
      SLOT_HI: begin
        if (tick && us_cnt == 9'd69) begin
          if (op_q == OP_BIT || bit_cnt == 3'd7) next_state = DONE;
          else                                   next_state = SLOT_LO;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The slot counter runs straight through SLOT_LO into SLOT_HI so both measure slot time
  always_comb begin
    cmd_ready = (state == IDLE) && !rsp_valid;
    accept    = cmd_valid && cmd_ready;
    tick      = (pre_cnt == PRE_MAX);
    cur_bit   = data_q[bit_cnt];
    oe_next   = (next_state == RST_LO) || (next_state == SLOT_LO);
    cnt_clear = (state == IDLE) || (state == DONE) ||
                ((next_state != state) && (state != SLOT_LO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owr_meta     <= 1'b1;
      owr_s        <= 1'b1;
      owr_oe       <= 1'b0;
      pre_cnt      <= '0;
      us_cnt       <= '0;
      op_q         <= OP_RESET;
      data_q       <= '0;
      bit_cnt      <= '0;
      rd_shift     <= '0;
      rd_bit       <= 1'b0;
      pres_q       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_presence <= 1'b0;
    end else begin
      owr_meta  <= owr_i;
      owr_s     <= owr_meta;
      owr_oe    <= oe_next;
      rsp_valid <= (state == DONE);

      if (cnt_clear) begin
        pre_cnt <= '0;
        us_cnt  <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        us_cnt  <= us_cnt + 9'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      if (accept) begin
        op_q     <= cmd_op;
        data_q   <= cmd_data;
        bit_cnt  <= '0;
        rd_shift <= '0;
        pres_q   <= 1'b0;
      end

      if (state == RST_WT && tick && us_cnt == 9'd69) pres_q <= ~owr_s;

      // Write-0 slots are still low at 15 us and never reach this sample, so they read 0
      if (state == SLOT_HI && tick && us_cnt == 9'd14) rd_bit <= owr_s;

      if (state == SLOT_HI && tick && us_cnt == 9'd69) begin
        rd_shift <= {cur_bit & rd_bit, rd_shift[7:1]};
        if (next_state == SLOT_LO) bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == DONE) begin
        case (op_q)
          OP_RESET: rsp_data <= 8'h00;
          OP_BYTE:  rsp_data <= rd_shift;
          OP_BIT:   rsp_data <= {7'b0, rd_shift[7]};
          default:  rsp_data <= 8'hFF;
        endcase
        rsp_presence <= (op_q == OP_RESET) && pres_q;
      end
    end
  end

endmodule

// File: tb/tb_onewire_ctrl.sv
// tb_onewire_ctrl: directed commands with a response scoreboard and a
// low-pulse-width scoreboard; a small slave model drives the wire.
module tb_onewire_ctrl;

  localparam int CPU = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       owr_oe;
  logic       owr_i;

  logic       slave_pull = 1'b0;
  int         slave_mode = 0;
  logic [7:0] slave_pattern = 8'hFF;
  logic [2:0] slave_idx = 3'd0;

  typedef struct {
    logic [7:0] data;
    logic       chk_data;
    logic       pres;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   exp_pulse[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rsp_cyc = 0;
  int   hi_cnt = 0;
  bit   pulse_chk_en = 1'b1;

  onewire_ctrl #(.CLK_PER_US(CPU)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_presence(rsp_presence), .owr_oe(owr_oe), .owr_i(owr_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign owr_i = ~(owr_oe | slave_pull);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Slave: mode 1 answers a reset with presence 15..120 us after release,
  // mode 2 holds the line low for 30 us in slots whose pattern bit is 0
  initial begin
    forever begin
      @(owr_oe);
      if (slave_mode == 1 && owr_oe === 1'b0) begin
        repeat (15 * CPU) @(posedge clk);
        slave_pull = 1'b1;
        repeat (105 * CPU) @(posedge clk);
        slave_pull = 1'b0;
      end else if (slave_mode == 2 && owr_oe === 1'b1) begin
        if (!slave_pattern[slave_idx]) begin
          slave_pull = 1'b1;
          repeat (30 * CPU) @(posedge clk);
          slave_pull = 1'b0;
        end
        slave_idx = slave_idx + 3'd1;
      end
    end
  end

  // Response monitor pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    if (rst_n && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_data) checkOutput("rsp_data", int'(rsp_data), int'(e.data));
        checkOutput("rsp_presence", int'(rsp_presence), int'(e.pres));
        checkOutput("rsp_latency", cyc - e.acc, e.lat);
      end
      last_rsp_cyc = cyc;
    end
  end

  // Pulse monitor measures each owr_oe low-drive pulse in clocks
  always @(negedge clk) begin
    if (owr_oe === 1'b1) begin
      hi_cnt++;
    end else if (hi_cnt > 0) begin
      if (pulse_chk_en) begin
        if (exp_pulse.size() == 0) checkOutput("unexpected_pulse", hi_cnt, 0);
        else                       checkOutput("pulse_width", hi_cnt, exp_pulse.pop_front());
      end
      hi_cnt = 0;
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data,
                               input logic [7:0] e_data, input bit e_chk, input bit e_pres,
                               input int e_lat, input bit do_push, input bit hold,
                               output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) checkOutput("cmd_ready_timeout", 0, 1);
    acc = cyc + 1;
    if (do_push) begin
      e.data = e_data; e.chk_data = e_chk; e.pres = e_pres; e.lat = e_lat; e.acc = acc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || owr_oe === 1'b1) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) checkOutput("rsp_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pushSlots(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) exp_pulse.push_back(d[i] ? 6 * CPU : 60 * CPU);
  endtask

  initial begin
    int acc, acc2;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_data", int'(rsp_data), 0);
    checkOutput("reset_rsp_presence", int'(rsp_presence), 0);
    checkOutput("reset_owr_oe", int'(owr_oe), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    slave_mode = 1;
    exp_pulse.push_back(480 * CPU);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 960 * CPU + 1, 1'b1, 1'b0, acc);
    waitIdle();

    slave_mode = 0;
    exp_pulse.push_back(480 * CPU);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 960 * CPU + 1, 1'b1, 1'b0, acc);
    waitIdle();

    pushSlots(8'h55, 8);
    applyStimulus(2'b01, 8'h55, 8'h55, 1'b1, 1'b0, 8 * 70 * CPU + 1, 1'b1, 1'b0, acc);
    waitIdle();

    slave_mode = 2; slave_idx = 3'd0; slave_pattern = 8'hA3;
    pushSlots(8'hFF, 8);
    applyStimulus(2'b01, 8'hFF, 8'hA3, 1'b1, 1'b0, 8 * 70 * CPU + 1, 1'b1, 1'b0, acc);
    waitIdle();
    slave_mode = 0;

    pushSlots(8'h00, 1);
    applyStimulus(2'b10, 8'h00, 8'h00, 1'b1, 1'b0, 70 * CPU + 1, 1'b1, 1'b1, acc);
    checkOutput("busy_cmd_ready", int'(cmd_ready), 0);
    cmd_data = 8'h01;
    pushSlots(8'h01, 1);
    applyStimulus(2'b10, 8'h01, 8'h01, 1'b1, 1'b0, 70 * CPU + 1, 1'b1, 1'b0, acc2);
    checkOutput("b2b_accept_cycle", acc2, last_rsp_cyc + 2);
    waitIdle();

    applyStimulus(2'b11, 8'h12, 8'hFF, 1'b1, 1'b0, 1, 1'b1, 1'b0, acc);
    waitIdle();

    pulse_chk_en = 1'b0;
    applyStimulus(2'b01, 8'h55, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, acc);
    repeat (3 * 70 * CPU + 10) @(negedge clk);
    checkOutput("abort_oe_before", int'(owr_oe), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_oe_dropped", int'(owr_oe), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    exp_pulse.delete();
    repeat (2) @(negedge clk);
    pulse_chk_en = 1'b1;
    checkOutput("abort_idle_ready", int'(cmd_ready), 1);

    slave_mode = 1;
    exp_pulse.push_back(480 * CPU);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 960 * CPU + 1, 1'b1, 1'b0, acc);
    waitIdle();
    slave_mode = 0;

    checkOutput("pulses_outstanding", exp_pulse.size(), 0);
    checkOutput("rsp_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
